// File: rtl/inst_byte_loader_if.sv
// rtl/inst_byte_loader_if.sv - pad and instruction-RAM write bus for the byte loader
interface inst_byte_loader_if #(
  parameter int ADDR_W = 5
);
  logic              load_en;
  logic              byte_strobe;
  logic [7:0]        byte_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic [ADDR_W:0]   words_loaded;
  logic              overflow;

  // loader side: consumes pad levels, drives the RAM write port and status
  modport master (
    input  load_en, byte_strobe, byte_data,
    output mem_we, mem_addr, mem_wdata, cpu_hold, words_loaded, overflow
  );

  // pad/RAM side
  modport slave (
    output load_en, byte_strobe, byte_data,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, words_loaded, overflow
  );
endinterface

// File: rtl/inst_byte_loader.sv
// rtl/inst_byte_loader.sv - packs pad bytes into 32-bit words and writes them to instruction RAM
module inst_byte_loader #(
  parameter int ADDR_W       = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int DRAIN_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  inst_byte_loader_if.master bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_W:0]   WORDS_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {RUN, LOAD, WRITE, FLUSH, DRAIN} state_t;

  logic [1:0] rst_pipe;
  logic       arst_n;

  logic [SYNC_STAGES-1:0]      load_sync;
  logic [SYNC_STAGES-1:0]      strobe_sync;
  logic [SYNC_STAGES-1:0][7:0] data_pipe;
  logic                        strobe_prev;
  logic                        load_prev;
  logic                        pulse;
  logic [7:0]                  byte_r;
  logic                        load_s;
  logic                        load_rise;

  state_t            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              ovf_q, ovf_d;
  logic              pend_q, pend_d;
  logic [7:0]        pend_byte_q, pend_byte_d;
  logic [CNT_W-1:0]  drain_q, drain_d;

  logic              take;
  logic [7:0]        take_byte;
  logic [31:0]       word_new;

  // reset asserts immediately but releases only on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign arst_n = rst_pipe[1];

  // pad synchronizers, strobe edge detect and data alignment with the pulse
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      load_sync   <= '0;
      strobe_sync <= '0;
      data_pipe   <= '0;
      strobe_prev <= 1'b0;
      load_prev   <= 1'b0;
      pulse       <= 1'b0;
      byte_r      <= 8'h00;
    end else begin
      load_sync   <= {load_sync[SYNC_STAGES-2:0], bus.load_en};
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], bus.byte_strobe};
      data_pipe   <= {data_pipe[SYNC_STAGES-2:0], bus.byte_data};
      strobe_prev <= strobe_sync[SYNC_STAGES-1];
      load_prev   <= load_sync[SYNC_STAGES-1];
      pulse       <= strobe_sync[SYNC_STAGES-1] & ~strobe_prev;
      byte_r      <= data_pipe[SYNC_STAGES-1];
    end
  end

  assign load_s    = load_sync[SYNC_STAGES-1];
  assign load_rise = load_s & ~load_prev;

  // state and datapath registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= RUN;
      lane_q      <= 2'd0;
      word_q      <= 32'h0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      words_q     <= '0;
      ovf_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_byte_q <= 8'h00;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      words_q     <= words_d;
      ovf_q       <= ovf_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      drain_q     <= drain_d;
    end
  end

  // next-state and datapath update; a held-over byte always goes in before a new one
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    word_d      = word_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    words_d     = words_q;
    ovf_d       = ovf_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    drain_d     = drain_q;
    take        = 1'b0;
    take_byte   = byte_r;
    word_new    = word_q;

    case (state_q)
      RUN: begin
        pend_d = 1'b0;
        if (load_rise) begin
          state_d = LOAD;
          addr_d  = '0;
          lane_d  = 2'd0;
          word_d  = 32'h0;
          words_d = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (pend_q) begin
          take      = 1'b1;
          take_byte = pend_byte_q;
          pend_d    = pulse;
          if (pulse) pend_byte_d = byte_r;
        end else if (pulse) begin
          take = 1'b1;
        end
        if (take) word_new[{lane_q, 3'b000} +: 8] = take_byte;
        if (take) begin
          word_d = word_new;
          lane_d = lane_q + 2'd1;
        end
        if (take && lane_q == 2'd3) begin
          state_d = WRITE;
          wdata_d = word_new;
        end else if (!load_s) begin
          if (take || lane_q != 2'd0) begin
            state_d = FLUSH;
            wdata_d = word_new;
          end else begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      WRITE, FLUSH: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) ovf_d = 1'b1;
        if (words_q != WORDS_MAX) words_d = words_q + 1'b1;
        lane_d = 2'd0;
        word_d = 32'h0;
        if (state_q == WRITE) begin
          state_d = LOAD;
          if (pulse) begin
            pend_d      = 1'b1;
            pend_byte_d = byte_r;
          end
        end else begin
          state_d = DRAIN;
          drain_d = '0;
          pend_d  = 1'b0;
        end
      end
      DRAIN: begin
        pend_d = 1'b0;
        if (drain_q == DRAIN_LAST) state_d = RUN;
        else                       drain_d = drain_q + 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.mem_we       = (state_q == WRITE) || (state_q == FLUSH);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.cpu_hold     = (state_q != RUN);
  assign bus.words_loaded = words_q;
  assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_inst_byte_loader.sv
// tb/tb_inst_byte_loader.sv - directed self-checking bench for inst_byte_loader
module tb_inst_byte_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [4:0]  wa [$];
  logic [31:0] wd [$];

  inst_byte_loader_if #(.ADDR_W(5)) bus ();

  inst_byte_loader #(.ADDR_W(5), .SYNC_STAGES(2), .DRAIN_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // record every RAM write, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_data   = b;
    bus.byte_strobe = 1'b1;
    cyc(2);
    bus.byte_strobe = 1'b0;
    cyc(2);
  endtask

  task automatic start_load;
    bus.load_en = 1'b1;
    cyc(6);
  endtask

  task automatic end_load;
    bus.load_en = 1'b0;
    cyc(15);
  endtask

  initial begin
    int base;
    int n;
    bit seen;
    bus.load_en     = 1'b0;
    bus.byte_strobe = 1'b0;
    bus.byte_data   = 8'h00;

    // 1: reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we",    32'(bus.mem_we), 32'h0);
    chk("rst_hold",  32'(bus.cpu_hold), 32'h0);
    chk("rst_addr",  32'(bus.mem_addr), 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_words", 32'(bus.words_loaded), 32'h0);
    chk("rst_ovf",   32'(bus.overflow), 32'h0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);

    // 2: one full word
    base = wa.size();
    start_load;
    chk("t2_hold", 32'(bus.cpu_hold), 32'h1);
    send(8'h13); send(8'h00); send(8'h50); send(8'h00);
    end_load;
    chk("t2_count", 32'(wa.size() - base), 32'd1);
    if (wa.size() > base) begin
      chk("t2_addr", 32'(wa[base]), 32'd0);
      chk("t2_data", wd[base], 32'h00500013);
    end
    chk("t2_words", 32'(bus.words_loaded), 32'd1);
    chk("t2_hold_off", 32'(bus.cpu_hold), 32'h0);

    // 3: partial word flush and drain timing
    base = wa.size();
    start_load;
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'hEE); send(8'hFF);
    bus.load_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) seen = 1'b1;
    end
    chk("t3_flush_seen", 32'(seen), 32'h1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.cpu_hold !== 1'b1) break;
      n++;
    end
    chk("t3_drain_len", 32'(n), 32'd4);
    cyc(3);
    chk("t3_count", 32'(wa.size() - base), 32'd2);
    if (wa.size() >= base + 2) begin
      chk("t3_addr0", 32'(wa[base]), 32'd0);
      chk("t3_data0", wd[base], 32'hDDCCBBAA);
      chk("t3_addr1", 32'(wa[base+1]), 32'd1);
      chk("t3_data1", wd[base+1], 32'h0000FFEE);
    end
    chk("t3_words", 32'(bus.words_loaded), 32'd2);

    // 4: address wrap over 33 words
    base = wa.size();
    start_load;
    for (int k = 0; k < 31; k++)
      for (int j = 0; j < 4; j++) send(8'(4 * k + j));
    cyc(2);
    chk("t4_words31", 32'(bus.words_loaded), 32'd31);
    chk("t4_ovf31",   32'(bus.overflow), 32'h0);
    chk("t4_addr31",  32'(bus.mem_addr), 32'd31);
    for (int j = 0; j < 4; j++) send(8'(124 + j));
    cyc(2);
    chk("t4_words32", 32'(bus.words_loaded), 32'd32);
    chk("t4_ovf32",   32'(bus.overflow), 32'h1);
    chk("t4_addr32",  32'(bus.mem_addr), 32'd0);
    for (int j = 0; j < 4; j++) send(8'(128 + j));
    end_load;
    chk("t4_count", 32'(wa.size() - base), 32'd33);
    if (wa.size() >= base + 33) begin
      chk("t4_w31_addr", 32'(wa[base+31]), 32'd31);
      chk("t4_w31_data", wd[base+31], 32'h7F7E7D7C);
      chk("t4_w32_addr", 32'(wa[base+32]), 32'd0);
      chk("t4_w32_data", wd[base+32], 32'h83828180);
    end
    chk("t4_words_sat", 32'(bus.words_loaded), 32'd32);
    chk("t4_ovf_end",   32'(bus.overflow), 32'h1);

    // 5a: strobe held high yields one byte
    base = wa.size();
    start_load;
    chk("t5_ovf_clr", 32'(bus.overflow), 32'h0);
    bus.byte_data   = 8'h5A;
    bus.byte_strobe = 1'b1;
    cyc(6);
    bus.byte_data = 8'h77;
    cyc(14);
    bus.byte_strobe = 1'b0;
    cyc(3);
    send(8'h01); send(8'h02); send(8'h03);
    end_load;
    chk("t5_count", 32'(wa.size() - base), 32'd1);
    if (wa.size() > base) chk("t5_data", wd[base], 32'h0302015A);
    chk("t5_words", 32'(bus.words_loaded), 32'd1);

    // 5b: reset mid-load abandons the partial word
    base = wa.size();
    start_load;
    send(8'h10); send(8'h20);
    #3 rst_n = 1'b0;
    #1;
    chk("t5r_hold",  32'(bus.cpu_hold), 32'h0);
    chk("t5r_we",    32'(bus.mem_we), 32'h0);
    chk("t5r_words", 32'(bus.words_loaded), 32'h0);
    bus.load_en = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    chk("t5r_count", 32'(wa.size() - base), 32'd0);
    chk("t5r_hold2", 32'(bus.cpu_hold), 32'h0);

    // 6: densest strobe spacing across a word boundary
    base = wa.size();
    start_load;
    for (int i = 1; i <= 8; i++) begin
      bus.byte_data   = 8'(8'h11 * i);
      bus.byte_strobe = 1'b1;
      cyc(1);
      bus.byte_strobe = 1'b0;
      cyc(1);
    end
    cyc(4);
    end_load;
    chk("t6_count", 32'(wa.size() - base), 32'd2);
    if (wa.size() >= base + 2) begin
      chk("t6_data0", wd[base], 32'h44332211);
      chk("t6_data1", wd[base+1], 32'h88776655);
      chk("t6_addr1", 32'(wa[base+1]), 32'd1);
    end
    chk("t6_words", 32'(bus.words_loaded), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
